// File: rtl/param_fifo_buffer.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds and sticky overflow/underflow flags.
module param_fifo_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 32,
    parameter  int FWFT       = 0,
    parameter  int AF_THRESH  = DEPTH - 2,
    parameter  int AE_THRESH  = 2,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  clear,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] head;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign head         = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = read_en  & ~clear & ~empty;
    assign wr_acc = write_en & ~clear & (~full | rd_acc);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
            if (write_en && !wr_acc) overflow_d  = 1'b1;
            if (read_en  && !rd_acc) underflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; entries outside the occupied window are never observed.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = empty ? '0 : head;
            assign dout_valid = ~empty;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dout_valid_q;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else if (clear) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_valid_q <= rd_acc;
                    if (rd_acc) dout_q <= head;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Directed bench for param_fifo_buffer: a registered-read and an FWFT instance share
// stimulus and are checked against a queue model with an output scoreboard.
module tb_param_fifo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          clear = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] r_dout, f_dout;
    logic          r_dout_valid, f_dout_valid;
    logic          r_full, f_full, r_empty, f_empty;
    logic          r_af, f_af, r_ae, f_ae;
    logic [CW-1:0] r_count, f_count;
    logic          r_ovf, f_ovf, r_unf, f_unf;

    param_fifo_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_reg (
        .CLK(CLK), .nRST(nRST), .clear(clear), .write_en(write_en), .din(din),
        .read_en(read_en), .dout(r_dout), .dout_valid(r_dout_valid), .full(r_full),
        .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf)
    );

    param_fifo_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_fwft (
        .CLK(CLK), .nRST(nRST), .clear(clear), .write_en(write_en), .din(din),
        .read_en(read_en), .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 CLK = ~CLK;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int            n;
        logic [DW-1:0] head;
        n    = mq.size();
        head = (n > 0) ? mq[0] : '0;
        check({ctx, " reg.count"},      32'(r_count),      32'(n));
        check({ctx, " reg.full"},       32'(r_full),       32'(n == DEPTH));
        check({ctx, " reg.empty"},      32'(r_empty),      32'(n == 0));
        check({ctx, " reg.almost_full"},  32'(r_af),       32'(n >= AF));
        check({ctx, " reg.almost_empty"}, 32'(r_ae),       32'(n <= AE));
        check({ctx, " reg.overflow"},   32'(r_ovf),        32'(m_ovf));
        check({ctx, " reg.underflow"},  32'(r_unf),        32'(m_unf));
        check({ctx, " reg.dout_valid"}, 32'(r_dout_valid), 32'(exp_valid));
        check({ctx, " reg.dout"},       32'(r_dout),       32'(exp_dout));
        check({ctx, " fwft.count"},     32'(f_count),      32'(n));
        check({ctx, " fwft.overflow"},  32'(f_ovf),        32'(m_ovf));
        check({ctx, " fwft.underflow"}, 32'(f_unf),        32'(m_unf));
        check({ctx, " fwft.dout_valid"}, 32'(f_dout_valid), 32'(n > 0));
        check({ctx, " fwft.dout"},      32'(f_dout),       32'(head));
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge occupancy.
    task automatic step(input string ctx, input logic we, input logic [DW-1:0] d,
                        input logic re, input logic clr = 1'b0);
        bit rd_acc, wr_acc;
        write_en = we;
        din      = d;
        read_en  = re;
        clear    = clr;
        rd_acc   = re && !clr && (mq.size() > 0);
        wr_acc   = we && !clr && ((mq.size() < DEPTH) || rd_acc);
        if (clr) begin
            mq.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (we && !wr_acc) m_ovf = 1'b1;
            if (re && !rd_acc) m_unf = 1'b1;
            if (rd_acc) sb.push_back(mq.pop_front());
            if (wr_acc) mq.push_back(d);
        end
        @(posedge CLK);
        #1;
        write_en  = 1'b0;
        read_en   = 1'b0;
        clear     = 1'b0;
        exp_valid = rd_acc;
        if (clr) begin
            exp_dout = '0;
        end else if (rd_acc) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s scoreboard: observed empty expected entry", ctx);
            end else begin
                exp_dout = sb.pop_front();
            end
        end
        check_all(ctx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check_all("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // 1: fill to full, then one refused write
        step("t1 w11", 1'b1, 8'h11, 1'b0);
        step("t1 w22", 1'b1, 8'h22, 1'b0);
        step("t1 w33", 1'b1, 8'h33, 1'b0);
        check("t1 almost_full after 3rd", 32'(r_af), 32'(1));
        step("t1 w44", 1'b1, 8'h44, 1'b0);
        check("t1 full after 4th", 32'(r_full), 32'(1));
        step("t1 w55 overflow", 1'b1, 8'h55, 1'b0);

        // 2: drain with registered read, then one refused read
        for (int i = 0; i < 4; i++) step("t2 drain", 1'b0, 8'h00, 1'b1);
        check("t2 last dout", 32'(r_dout), 32'(8'h44));
        step("t2 underflow", 1'b0, 8'h00, 1'b1);
        check("t2 dout held", 32'(r_dout), 32'(8'h44));

        // 3: full with simultaneous write+read, wrap order kept
        step("t3 w11", 1'b1, 8'h11, 1'b0);
        step("t3 w22", 1'b1, 8'h22, 1'b0);
        step("t3 w33", 1'b1, 8'h33, 1'b0);
        step("t3 w44", 1'b1, 8'h44, 1'b0);
        step("t3 w66+rd", 1'b1, 8'h66, 1'b1);
        check("t3 simul dout", 32'(r_dout), 32'(8'h11));
        for (int i = 0; i < 4; i++) step("t3 drain", 1'b0, 8'h00, 1'b1);
        check("t3 wrapped tail", 32'(r_dout), 32'(8'h66));

        // 4: empty with simultaneous write+read: read refused, write kept
        step("t4 w77+rd", 1'b1, 8'h77, 1'b1);
        step("t4 rd", 1'b0, 8'h00, 1'b1);
        check("t4 dout", 32'(r_dout), 32'(8'h77));

        // 5: clear dominates, then async reset mid-burst
        step("t5 wA1", 1'b1, 8'hA1, 1'b0);
        step("t5 wA2", 1'b1, 8'hA2, 1'b0);
        step("t5 wA3", 1'b1, 8'hA3, 1'b0);
        step("t5 clear", 1'b1, 8'hEE, 1'b1, 1'b1);
        step("t5 wB1", 1'b1, 8'hB1, 1'b0);
        step("t5 wB2", 1'b1, 8'hB2, 1'b1);
        write_en = 1'b1;
        din      = 8'hBB;
        #2;
        nRST = 1'b0;
        #1;
        mq.delete();
        sb.delete();
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        exp_dout  = '0;
        exp_valid = 1'b0;
        check_all("t5 async reset");
        write_en = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // 6: FWFT write to empty shows next cycle, read empties it
        step("t6 wA5", 1'b1, 8'hA5, 1'b0);
        check("t6 fwft dout", 32'(f_dout), 32'(8'hA5));
        check("t6 fwft valid", 32'(f_dout_valid), 32'(1));
        step("t6 rd", 1'b0, 8'h00, 1'b1);
        check("t6 fwft dout after pop", 32'(f_dout), 32'(0));
        check("t6 fwft valid after pop", 32'(f_dout_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
